// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: moves (x_pos, y_pos) by STEP once per motion tick.
// Optional per-axis acceleration is enabled by defining the MOTION_ACCEL_EN macro.
module sprite_motion_ctrl #(
    parameter int WIDTH       = 16,
    parameter int TICK_CYCLES = 250_000,
    parameter int STEP        = 1,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_HOME      = 0,
    parameter int Y_HOME      = 0,
    parameter int WRAP        = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    input  logic             center,
    output logic [WIDTH-1:0] x_pos,
    output logic [WIDTH-1:0] y_pos,
    output logic             tick,
    output logic             moved,
    output logic             at_edge
);

    localparam int               CNT_W     = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_CYCLES - 1);
    localparam logic [WIDTH:0]   X_LIM     = (WIDTH+1)'(X_MAX);
    localparam logic [WIDTH:0]   Y_LIM     = (WIDTH+1)'(Y_MAX);
    localparam logic [WIDTH:0]   X_SPAN    = (WIDTH+1)'(X_MAX + 1);
    localparam logic [WIDTH:0]   Y_SPAN    = (WIDTH+1)'(Y_MAX + 1);
    localparam logic [WIDTH-1:0] X_MAX_P   = WIDTH'(X_MAX);
    localparam logic [WIDTH-1:0] Y_MAX_P   = WIDTH'(Y_MAX);
    localparam logic [WIDTH-1:0] X_HOME_P  = WIDTH'(X_HOME);
    localparam logic [WIDTH-1:0] Y_HOME_P  = WIDTH'(Y_HOME);
    localparam logic             HOME_EDGE = (X_HOME == 0) || (X_HOME == X_MAX) ||
                                             (Y_HOME == 0) || (Y_HOME == Y_MAX);

    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   step_y;
    logic [WIDTH-1:0] x_next;
    logic [WIDTH-1:0] y_next;
    logic             edge_next;
    logic             req_x;
    logic             req_y;

    // One extra bit of headroom lets both overflow and underflow be detected directly.
    function automatic logic [WIDTH-1:0] step_axis(
        input logic [WIDTH-1:0] pos,
        input logic             inc,
        input logic             dec,
        input logic [WIDTH:0]   step,
        input logic [WIDTH:0]   lim,
        input logic [WIDTH:0]   span
    );
        logic [WIDTH:0] wide;
        wide = {1'b0, pos};
        if (inc && !dec) begin
            wide = {1'b0, pos} + step;
            if (wide > lim)
                wide = (WRAP != 0) ? wide - span : lim;
        end else if (dec && !inc) begin
            if ({1'b0, pos} < step)
                wide = (WRAP != 0) ? {1'b0, pos} + span - step : '0;
            else
                wide = {1'b0, pos} - step;
        end
        return wide[WIDTH-1:0];
    endfunction

    assign tick  = (count == CNT_LAST);
    assign req_x = left ^ right;
    assign req_y = up ^ down;

`ifdef MOTION_ACCEL_EN
    logic [1:0] level_x;
    logic [1:0] level_y;
    logic [2:0] run_x;
    logic [2:0] run_y;

    assign step_x = (WIDTH+1)'(STEP) << level_x;
    assign step_y = (WIDTH+1)'(STEP) << level_y;

    // A level rises after every eight consecutive requesting ticks and drops on any idle tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_x <= '0;
            level_y <= '0;
            run_x   <= '0;
            run_y   <= '0;
        end else if (tick) begin
            if (center || !req_x) begin
                level_x <= '0;
                run_x   <= '0;
            end else if (run_x == 3'd7) begin
                run_x <= '0;
                if (level_x != 2'd3)
                    level_x <= level_x + 2'd1;
            end else begin
                run_x <= run_x + 3'd1;
            end

            if (center || !req_y) begin
                level_y <= '0;
                run_y   <= '0;
            end else if (run_y == 3'd7) begin
                run_y <= '0;
                if (level_y != 2'd3)
                    level_y <= level_y + 2'd1;
            end else begin
                run_y <= run_y + 3'd1;
            end
        end
    end
`else
    assign step_x = (WIDTH+1)'(STEP);
    assign step_y = (WIDTH+1)'(STEP);
`endif

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        x_next = x_pos;
        y_next = y_pos;
        if (tick) begin
            if (center) begin
                x_next = X_HOME_P;
                y_next = Y_HOME_P;
            end else begin
                x_next = step_axis(x_pos, right, left, step_x, X_LIM, X_SPAN);
                y_next = step_axis(y_pos, down, up, step_y, Y_LIM, Y_SPAN);
            end
        end
        edge_next = (x_next == '0) || (x_next == X_MAX_P) ||
                    (y_next == '0) || (y_next == Y_MAX_P);
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            x_pos   <= X_HOME_P;
            y_pos   <= Y_HOME_P;
            moved   <= 1'b0;
            at_edge <= HOME_EDGE;
        end else begin
            count   <= tick ? '0 : count + 1'b1;
            x_pos   <= x_next;
            y_pos   <= y_next;
            moved   <= tick && ((x_next != x_pos) || (y_next != y_pos));
            at_edge <= edge_next;
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: a clamping and a wrapping instance share stimulus,
// a behavioural model queues expected results at each tick and a monitor compares them.
module tb_sprite_motion_ctrl;

    localparam int TC    = 4;
    localparam int STEP  = 1;
    localparam int XM    = 9;
    localparam int YM    = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, center = 1'b0;

    logic [15:0] x_c, y_c, x_w, y_w;
    logic        tick_c, moved_c, at_edge_c;
    logic        tick_w, moved_w, at_edge_w;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int xc, yc, xw, yw;
        bit mc, mw, ec, ew;
    } exp_t;

    exp_t sb[$];
    int   m_cnt = 0;
    int   mxc = 0, myc = 0, mxw = 0, myw = 0;
    int   lvl_x = 0, lvl_y = 0, run_x = 0, run_y = 0;

    always #5 clk = ~clk;

    sprite_motion_ctrl #(
        .WIDTH(16), .TICK_CYCLES(TC), .STEP(STEP), .X_MAX(XM), .Y_MAX(YM),
        .X_HOME(0), .Y_HOME(0), .WRAP(0)
    ) dut_clamp (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .center(center), .x_pos(x_c), .y_pos(y_c), .tick(tick_c), .moved(moved_c),
        .at_edge(at_edge_c)
    );

    sprite_motion_ctrl #(
        .WIDTH(16), .TICK_CYCLES(TC), .STEP(STEP), .X_MAX(XM), .Y_MAX(YM),
        .X_HOME(0), .Y_HOME(0), .WRAP(1)
    ) dut_wrap (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .center(center), .x_pos(x_w), .y_pos(y_w), .tick(tick_w), .moved(moved_w),
        .at_edge(at_edge_w)
    );

`ifdef MOTION_ACCEL_EN
    logic [15:0] x_a, y_a;
    logic        tick_a, moved_a, at_edge_a;

    sprite_motion_ctrl #(
        .WIDTH(16), .TICK_CYCLES(TC), .STEP(STEP), .X_MAX(200), .Y_MAX(YM),
        .X_HOME(0), .Y_HOME(0), .WRAP(0)
    ) dut_acc (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .center(center), .x_pos(x_a), .y_pos(y_a), .tick(tick_a), .moved(moved_a),
        .at_edge(at_edge_a)
    );
`endif

    function automatic int m_axis(input int pos, input bit inc, input bit dec,
                                  input int step, input int mx, input bit wrap);
        int r;
        r = pos;
        if (inc && !dec)
            r = pos + step;
        else if (dec && !inc)
            r = pos - step;
        if (r > mx)
            r = wrap ? r - (mx + 1) : mx;
        else if (r < 0)
            r = wrap ? r + (mx + 1) : 0;
        return r;
    endfunction

    function automatic bit m_edge(input int x, input int y);
        return (x == 0) || (x == XM) || (y == 0) || (y == YM);
    endfunction

    // Reference model: evaluates each tick from the inputs and queues the expected outputs.
    initial begin
        exp_t e;
        int   sx, sy;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cnt = 0;
                mxc = 0; myc = 0; mxw = 0; myw = 0;
                lvl_x = 0; lvl_y = 0; run_x = 0; run_y = 0;
                sb.delete();
            end else begin
                if (m_cnt == TC - 1) begin
`ifdef MOTION_ACCEL_EN
                    sx = STEP << lvl_x;
                    sy = STEP << lvl_y;
`else
                    sx = STEP;
                    sy = STEP;
`endif
                    if (center) begin
                        e.xc = 0; e.yc = 0; e.xw = 0; e.yw = 0;
                    end else begin
                        e.xc = m_axis(mxc, right, left, sx, XM, 1'b0);
                        e.yc = m_axis(myc, down, up, sy, YM, 1'b0);
                        e.xw = m_axis(mxw, right, left, sx, XM, 1'b1);
                        e.yw = m_axis(myw, down, up, sy, YM, 1'b1);
                    end
                    e.mc = (e.xc != mxc) || (e.yc != myc);
                    e.mw = (e.xw != mxw) || (e.yw != myw);
                    e.ec = m_edge(e.xc, e.yc);
                    e.ew = m_edge(e.xw, e.yw);
                    mxc = e.xc; myc = e.yc; mxw = e.xw; myw = e.yw;
                    if (center || !(right ^ left)) begin
                        lvl_x = 0; run_x = 0;
                    end else if (run_x == 7) begin
                        run_x = 0;
                        if (lvl_x < 3) lvl_x++;
                    end else begin
                        run_x++;
                    end
                    if (center || !(up ^ down)) begin
                        lvl_y = 0; run_y = 0;
                    end else if (run_y == 7) begin
                        run_y = 0;
                        if (lvl_y < 3) lvl_y++;
                    end else begin
                        run_y++;
                    end
                    sb.push_back(e);
                end
                m_cnt = (m_cnt + 1) % TC;
            end
        end
    end

    // Monitor: tick every cycle, and the queued result in the cycle after each tick.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if (tick_c !== (m_cnt == TC - 1) || tick_w !== (m_cnt == TC - 1)) begin
                    errors++;
                    $display("FAIL tick: got %b/%b want %b", tick_c, tick_w, m_cnt == TC - 1);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (x_c !== 16'(e.xc) || y_c !== 16'(e.yc)) begin
                        errors++;
                        $display("FAIL pos_clamp: got (%0d,%0d) want (%0d,%0d)", x_c, y_c, e.xc, e.yc);
                    end
                    checks++;
                    if (x_w !== 16'(e.xw) || y_w !== 16'(e.yw)) begin
                        errors++;
                        $display("FAIL pos_wrap: got (%0d,%0d) want (%0d,%0d)", x_w, y_w, e.xw, e.yw);
                    end
                    checks++;
                    if (moved_c !== e.mc || moved_w !== e.mw) begin
                        errors++;
                        $display("FAIL moved: got %b/%b want %b/%b", moved_c, moved_w, e.mc, e.mw);
                    end
                    checks++;
                    if (at_edge_c !== e.ec || at_edge_w !== e.ew) begin
                        errors++;
                        $display("FAIL at_edge: got %b/%b want %b/%b", at_edge_c, at_edge_w, e.ec, e.ew);
                    end
                end else begin
                    checks++;
                    if (moved_c !== 1'b0 || moved_w !== 1'b0) begin
                        errors++;
                        $display("FAIL moved_idle: got %b/%b want 0/0", moved_c, moved_w);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    // Returns at the falling edge just after the next tick edge.
    task automatic wait_tick_end();
        int n = 0;
        @(negedge clk);
        while (m_cnt != TC - 1 && n < 2 * TC) begin
            @(negedge clk);
            n++;
        end
        if (m_cnt != TC - 1) begin
            checks++;
            errors++;
            $display("FAIL tick_wait: got no tick within %0d cycles want tick", 2 * TC);
        end
        @(negedge clk);
    endtask

    task automatic apply(input bit u, input bit d, input bit l, input bit r,
                         input bit c, input int n);
        up = u; down = d; left = l; right = r; center = c;
        repeat (n) wait_tick_end();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (x_c !== 16'd0 || y_c !== 16'd0 || x_w !== 16'd0 || y_w !== 16'd0) begin
            errors++;
            $display("FAIL reset_pos: got (%0d,%0d)/(%0d,%0d) want (0,0)", x_c, y_c, x_w, y_w);
        end
        checks++;
        if (tick_c !== 1'b0 || moved_c !== 1'b0 || at_edge_c !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: got tick %b moved %b edge %b want 0 0 1",
                     tick_c, moved_c, at_edge_c);
        end
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    task automatic test_pulse_off_tick();
        int n = 0;
        @(negedge clk);
        while (m_cnt != 1 && n < 2 * TC) begin
            @(negedge clk);
            n++;
        end
        right = 1'b1;
        @(negedge clk);
        right = 1'b0;
        wait_tick_end();
        checks++;
        if (x_c !== 16'd0 || x_w !== 16'd0) begin
            errors++;
            $display("FAIL pulse_ignored: got x %0d/%0d want 0/0", x_c, x_w);
        end
    endtask

    task automatic test_wrap_edges();
        apply(0, 0, 1, 0, 0, 1);
        checks++;
        if (x_c !== 16'd0 || x_w !== 16'd9) begin
            errors++;
            $display("FAIL left_from_0: got x %0d/%0d want 0/9", x_c, x_w);
        end
        apply(1, 0, 0, 0, 0, 1);
        checks++;
        if (y_c !== 16'd0 || y_w !== 16'd7) begin
            errors++;
            $display("FAIL up_from_0: got y %0d/%0d want 0/7", y_c, y_w);
        end
        apply(0, 1, 0, 0, 0, 1);
        checks++;
        if (y_c !== 16'd1 || y_w !== 16'd0) begin
            errors++;
            $display("FAIL down_from_max: got y %0d/%0d want 1/0", y_c, y_w);
        end
        apply(0, 0, 0, 0, 1, 1);
    endtask

    task automatic test_clamp_right();
        int pulses = 0;
        apply(0, 0, 0, 1, 0, 10);
        checks++;
        if (x_c !== 16'd9 || at_edge_c !== 1'b1) begin
            errors++;
            $display("FAIL clamp_right: got x %0d edge %b want 9 1", x_c, at_edge_c);
        end
        repeat (2 * TC) begin
            @(negedge clk);
            if (moved_c) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL clamp_no_moved: got %0d pulses want 0", pulses);
        end
        apply(0, 0, 0, 0, 1, 1);
    endtask

    task automatic test_diag_center();
        apply(0, 1, 0, 1, 0, 1);
        checks++;
        if (x_c !== 16'd1 || y_c !== 16'd1) begin
            errors++;
            $display("FAIL diag_1: got (%0d,%0d) want (1,1)", x_c, y_c);
        end
        apply(0, 1, 0, 1, 0, 1);
        checks++;
        if (x_c !== 16'd2 || y_c !== 16'd2) begin
            errors++;
            $display("FAIL diag_2: got (%0d,%0d) want (2,2)", x_c, y_c);
        end
        apply(0, 1, 0, 1, 1, 1);
        checks++;
        if (x_c !== 16'd0 || y_c !== 16'd0) begin
            errors++;
            $display("FAIL center_override: got (%0d,%0d) want (0,0)", x_c, y_c);
        end
        apply(0, 1, 0, 1, 0, 1);
        apply(1, 1, 1, 1, 0, 1);
        checks++;
        if (x_c !== 16'd1 || y_c !== 16'd1) begin
            errors++;
            $display("FAIL conflict_hold: got (%0d,%0d) want (1,1)", x_c, y_c);
        end
        apply(0, 0, 0, 0, 1, 1);
    endtask

    task automatic test_reset_mid();
        int found = 0;
        apply(0, 0, 0, 1, 0, 5);
        apply(0, 0, 0, 0, 0, 0);
        checks++;
        if (x_c !== 16'd5) begin
            errors++;
            $display("FAIL pre_reset_x: got %0d want 5", x_c);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (x_c !== 16'd0 || x_w !== 16'd0 || tick_c !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got x %0d/%0d tick %b want 0/0 0", x_c, x_w, tick_c);
        end
        release_reset();
        for (int i = 1; i <= 3 * TC; i++) begin
            @(negedge clk);
            if (tick_c && found == 0) found = i;
            @(posedge clk);
        end
        checks++;
        if (found != TC) begin
            errors++;
            $display("FAIL tick_after_reset: got tick in cycle %0d want %0d", found, TC);
        end
    endtask

`ifdef MOTION_ACCEL_EN
    task automatic test_accel();
        apply(0, 0, 0, 0, 1, 1);
        apply(0, 0, 0, 1, 0, 8);
        checks++;
        if (x_a !== 16'd8) begin
            errors++;
            $display("FAIL accel_8: got x %0d want 8", x_a);
        end
        apply(0, 0, 0, 1, 0, 4);
        checks++;
        if (x_a !== 16'd16) begin
            errors++;
            $display("FAIL accel_12: got x %0d want 16", x_a);
        end
        apply(0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 1, 0, 1);
        checks++;
        if (x_a !== 16'd17) begin
            errors++;
            $display("FAIL accel_release: got x %0d want 17", x_a);
        end
        apply(0, 0, 0, 0, 1, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_pulse_off_tick();
        test_wrap_edges();
        test_clamp_right();
        test_diag_center();
        test_reset_mid();
`ifdef MOTION_ACCEL_EN
        test_accel();
`endif
        apply(0, 0, 0, 0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
